// File: rtl/countdown_ctrl.sv
// Countdown controller with an integrated down-counter datapath.
// A start value is loaded, then decremented by a programmable step once every
// PRESCALE clocks until it reaches zero, where a one-cycle done pulse is
// produced. Supports pause, abort and periodic auto-reload.
module countdown_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_disp
);

  // Prescaler only needs to reach PRESCALE-1; keep at least one bit so the
  // PRESCALE=1 case (tick every cycle) still has a legal register.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_next;
  logic             tick;
  logic [WIDTH-1:0] tick_val;

  // A zero step would stall the countdown forever, so it behaves as one.
  function automatic logic [WIDTH-1:0] eff_step(input logic [WIDTH-1:0] s);
    return (s == '0) ? WIDTH'(1) : s;
  endfunction

  // Subtract with a floor at zero so the count never wraps past zero.
  function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (a <= b) ? '0 : (a - b);
  endfunction

  // State, count, captured reload value and prescaler registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      reload_reg <= '0;
      presc      <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      presc      <= presc_next;
    end
  end

  // Next-state and datapath update; abort beats pause, pause beats tick/start.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload_reg;
    presc_next  = presc;
    tick        = (presc == PS_LAST);
    tick_val    = sat_sub(count, eff_step(step));

    case (state)
      S_IDLE: begin
        if (start) begin
          reload_next = load_val;
          state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_next = S_IDLE;
        end else begin
          count_next = reload_reg;
          presc_next = '0;
          state_next = (reload_reg == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (pause) begin
          state_next = S_PAUSE;
        end else if (tick) begin
          count_next = tick_val;
          presc_next = '0;
          if (tick_val == '0) begin
            state_next = S_DONE;
          end
        end else begin
          presc_next = presc + 1'b1;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (!pause) begin
          state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_next = S_IDLE;
        end else begin
          count_next = '0;
          if (start) begin
            reload_next = load_val;
            state_next  = S_LOAD;
          end else if (auto_reload) begin
            state_next = S_LOAD;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded straight from the state register.
  always_comb begin
    busy       = (state == S_LOAD) || (state == S_RUN) || (state == S_PAUSE);
    done       = (state == S_DONE);
    state_disp = state;
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl. Two instances (PRESCALE=1 and 4) share
// stimulus; expected per-cycle count/state values are queued before each
// sequence and popped one per cycle on the falling edge.
module tb_countdown_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] load_val;
  logic [7:0] step;
  logic       auto_reload;
  logic       pause;
  logic       abort;

  logic [7:0] count1, count4;
  logic       busy1, busy4;
  logic       done1, done4;
  logic [2:0] st1, st4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] c;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];

  localparam int I = 0, L = 1, R = 2, P = 3, D = 4;

  countdown_ctrl #(.WIDTH(8), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .step(step), .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .count(count1), .busy(busy1), .done(done1), .state_disp(st1)
  );

  countdown_ctrl #(.WIDTH(8), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .step(step), .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .count(count4), .busy(busy4), .done(done4), .state_disp(st4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input int c, input int st);
    exp_t e;
    e.c  = 8'(c);
    e.st = 3'(st);
    sb.push_back(e);
  endtask

  task automatic push_n(input int n, input int c, input int st);
    for (int k = 0; k < n; k++) push(c, st);
  endtask

  task automatic check_n(input int sel, input int n, input string tag);
    exp_t       e;
    logic [7:0] oc;
    logic       ob, od, eb, ed;
    logic [2:0] os;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 0) begin
        oc = count1; ob = busy1; od = done1; os = st1;
      end else begin
        oc = count4; ob = busy4; od = done4; os = st4;
      end
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s[%0d] scoreboard empty got_state=%0d", tag, i, os);
      end else begin
        e  = sb.pop_front();
        eb = (e.st == 3'(L)) || (e.st == 3'(R)) || (e.st == 3'(P));
        ed = (e.st == 3'(D));
        checks++;
        assert (oc === e.c) else begin
          failures++;
          $error("FAIL %s[%0d] count got=%0d exp=%0d", tag, i, oc, e.c);
        end
        checks++;
        assert (os === e.st) else begin
          failures++;
          $error("FAIL %s[%0d] state got=%0d exp=%0d", tag, i, os, e.st);
        end
        checks++;
        assert (ob === eb) else begin
          failures++;
          $error("FAIL %s[%0d] busy got=%0b exp=%0b", tag, i, ob, eb);
        end
        checks++;
        assert (od === ed) else begin
          failures++;
          $error("FAIL %s[%0d] done got=%0b exp=%0b", tag, i, od, ed);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push(0, I);
    check_n(0, 1, "reset_p1");
    push(0, I);
    check_n(1, 1, "reset_p4");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; load_val = '0; step = 8'd1;
    auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;

    do_reset();

    // Basic countdown from 5, step 1: done in cycle 7.
    start = 1'b1; load_val = 8'd5; step = 8'd1;
    push(0, L); push(5, R); push(4, R); push(3, R); push(2, R); push(1, R);
    push(0, D); push(0, I);
    check_n(0, 1, "basic");
    start = 1'b0;
    check_n(0, 7, "basic");

    // PRESCALE=4, load 10, step 3: saturates at 0, done in cycle 18.
    do_reset();
    start = 1'b1; load_val = 8'd10; step = 8'd3;
    push(0, L);
    push_n(4, 10, R); push_n(4, 7, R); push_n(4, 4, R); push_n(4, 1, R);
    push(0, D); push(0, I);
    check_n(1, 1, "presc4");
    start = 1'b0;
    check_n(1, 18, "presc4");

    // Load 0 goes straight to done.
    do_reset();
    start = 1'b1; load_val = 8'd0; step = 8'd1;
    push(0, L); push(0, D); push(0, I);
    check_n(0, 1, "load0");
    start = 1'b0;
    check_n(0, 2, "load0");

    // Step 0 acts as step 1.
    start = 1'b1; load_val = 8'd3; step = 8'd0;
    push(0, L); push(3, R); push(2, R); push(1, R); push(0, D); push(0, I);
    check_n(0, 1, "step0");
    start = 1'b0;
    check_n(0, 5, "step0");

    // Step larger than count clamps to 0 in one tick.
    start = 1'b1; load_val = 8'd200; step = 8'd250;
    push(0, L); push(200, R); push(0, D); push(0, I);
    check_n(0, 1, "bigstep");
    start = 1'b0;
    check_n(0, 3, "bigstep");
    step = 8'd1;

    // Pause at count 3 for 9 sampled cycles: 10 cycles of delay overall.
    start = 1'b1; load_val = 8'd6;
    push(0, L); push(6, R); push(5, R); push(4, R); push(3, R);
    push_n(9, 3, P);
    push(3, R); push(2, R); push(1, R); push(0, D); push(0, I);
    check_n(0, 1, "pause");
    start = 1'b0;
    check_n(0, 4, "pause");
    pause = 1'b1;
    check_n(0, 9, "pause");
    pause = 1'b0;
    check_n(0, 5, "pause");

    // Auto-reload every 5 cycles, then a start in S_DONE swaps in 7.
    auto_reload = 1'b1; start = 1'b1; load_val = 8'd3;
    push(0, L); push(3, R); push(2, R); push(1, R); push(0, D);
    push(0, L); push(3, R); push(2, R); push(1, R); push(0, D);
    push(0, L);
    push(7, R); push(6, R); push(5, R); push(4, R); push(3, R); push(2, R);
    push(1, R); push(0, D); push(0, I);
    check_n(0, 1, "reload");
    start = 1'b0;
    check_n(0, 9, "reload");
    start = 1'b1; load_val = 8'd7;
    check_n(0, 1, "reload");
    start = 1'b0; load_val = 8'd9;
    check_n(0, 7, "reload");
    auto_reload = 1'b0;
    check_n(0, 2, "reload");

    // Abort at count 4: idle next cycle, count held, no done.
    start = 1'b1; load_val = 8'd6;
    push(0, L); push(6, R); push(5, R); push(4, R); push(4, I); push(4, I);
    check_n(0, 1, "abort");
    start = 1'b0;
    check_n(0, 3, "abort");
    abort = 1'b1;
    check_n(0, 1, "abort");
    abort = 1'b0;
    check_n(0, 1, "abort");

    // Reset in the middle of a run clears everything.
    start = 1'b1; load_val = 8'd6;
    push(4, L); push(6, R); push(5, R); push(0, I);
    check_n(0, 1, "rst_run");
    start = 1'b0;
    check_n(0, 2, "rst_run");
    reset = 1'b1;
    check_n(0, 1, "rst_run");
    reset = 1'b0;

    // Start and load_val changes while running are ignored.
    start = 1'b1; load_val = 8'd4;
    push(0, L); push(4, R); push(3, R); push(2, R); push(1, R); push(0, D);
    push(0, I);
    check_n(0, 1, "busy_start");
    start = 1'b0;
    check_n(0, 1, "busy_start");
    start = 1'b1; load_val = 8'd9;
    check_n(0, 1, "busy_start");
    start = 1'b0;
    check_n(0, 4, "busy_start");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL leftover scoreboard entries got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
